// File: rtl/snn_psum_accumulator.sv
// ============================================================================
// snn_psum_accumulator : per-channel saturating partial-sum accumulator with
// threshold-compare dump port and a one-entry output register.
// Revision: 1.0
// ============================================================================
`default_nettype none

module snn_psum_accumulator #(
  parameter int NCH        = 4,
  parameter int DW         = 8,
  parameter int AW         = 16,
  parameter int THRESH     = 64,
  parameter int RESET_MODE = 0,
  localparam int CW        = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [CW-1:0] in_chan,
  input  logic [DW-1:0] in_data,
  input  logic          clr_valid,
  output logic          clr_ready,
  input  logic [CW-1:0] clr_chan,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [CW-1:0] out_chan,
  output logic [AW-1:0] out_data,
  output logic          out_spike,
  output logic          out_sat
);

  localparam logic signed [AW-1:0] C_THRESH = AW'(THRESH);
  localparam logic signed [AW-1:0] C_MAX    = {1'b0, {(AW-1){1'b1}}};
  localparam logic signed [AW-1:0] C_MIN    = {1'b1, {(AW-1){1'b0}}};

  logic                 w_in_fire;
  logic                 w_clr_fire;
  logic signed [AW-1:0] w_acc   [NCH];
  logic                 w_sat   [NCH];
  logic                 w_spike [NCH];

  // Ready signals follow rst_n directly so they are held low during reset.
  assign in_ready   = rst_n;
  assign clr_ready  = rst_n & (~out_valid | out_ready);
  assign w_in_fire  = in_valid & in_ready;
  assign w_clr_fire = clr_valid & clr_ready;

  for (genvar c = 0; c < NCH; c++) begin : g_ch
    localparam logic [CW-1:0] C_IDX = CW'(c);

    logic signed [AW-1:0] r_acc;
    logic                 r_sat;
    logic                 w_in_hit;
    logic                 w_clr_hit;
    logic signed [AW-1:0] w_resid;
    logic signed [AW-1:0] w_base;
    logic        [AW:0]   w_sum;
    logic                 w_ovf;
    logic signed [AW-1:0] w_clamped;

    assign w_in_hit   = w_in_fire  && (in_chan  == C_IDX);
    assign w_clr_hit  = w_clr_fire && (clr_chan == C_IDX);
    assign w_spike[c] = (r_acc >= C_THRESH);
    assign w_resid    = (RESET_MODE == 1 && w_spike[c]) ? (r_acc - C_THRESH) : '0;
    // A colliding input adds onto the post-dump residual, not the old value.
    assign w_base     = w_clr_hit ? w_resid : r_acc;
    assign w_sum      = {w_base[AW-1], w_base} + {{(AW+1-DW){in_data[DW-1]}}, in_data};
    assign w_ovf      = w_sum[AW] ^ w_sum[AW-1];
    assign w_clamped  = w_ovf ? (w_sum[AW] ? C_MIN : C_MAX) : w_sum[AW-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_acc <= '0;
        r_sat <= 1'b0;
      end else if (w_in_hit) begin
        r_acc <= w_clamped;
        r_sat <= w_clr_hit ? w_ovf : (r_sat | w_ovf);
      end else if (w_clr_hit) begin
        r_acc <= w_resid;
        r_sat <= 1'b0;
      end
    end

    assign w_acc[c] = r_acc;
    assign w_sat[c] = r_sat;
  end

  logic                 w_sel_ok;
  logic signed [AW-1:0] w_sel_acc;
  logic                 w_sel_sat;
  logic                 w_sel_spike;

  always_comb begin
    w_sel_ok    = 1'b0;
    w_sel_acc   = '0;
    w_sel_sat   = 1'b0;
    w_sel_spike = 1'b0;
    for (int c = 0; c < NCH; c++) begin
      if (clr_chan == CW'(c)) begin
        w_sel_ok    = 1'b1;
        w_sel_acc   = w_acc[c];
        w_sel_sat   = w_sat[c];
        w_sel_spike = w_spike[c];
      end
    end
  end

  // Out-of-range dumps complete the handshake but load nothing.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_chan  <= '0;
      out_data  <= '0;
      out_spike <= 1'b0;
      out_sat   <= 1'b0;
    end else if (w_clr_fire && w_sel_ok) begin
      out_valid <= 1'b1;
      out_chan  <= clr_chan;
      out_data  <= w_sel_acc;
      out_spike <= w_sel_spike;
      out_sat   <= w_sel_sat;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

`default_nettype wire

// File: doc/snn_psum_accumulator.md
SNN_PSUM_ACCUMULATOR -- requirements
Module: snn_psum_accumulator

Interface
REQ-001 Parameters (name, default, meaning) SHALL be:
- NCH, 4, number of independent accumulator channels (>=1)
- DW, 8, signed input partial-sum width
- AW, 16, signed accumulator width (AW > DW)
- THRESH, 64, signed spike threshold (fits AW)
- RESET_MODE, 0, post-dump residual: 0 = zero, 1 = subtract THRESH when spiking
- CW is derived, SHALL equal max(1, $clog2(NCH)), and is not overridable.
REQ-002 Ports (name, direction, width, meaning) SHALL be:
- clk  in  1  single clock, all state on rising edge
- rst_n  in  1  reset, asynchronous assert, active-low
- in_valid  in  1  partial-sum request
- in_ready  out  1  partial-sum accept
- in_chan  in  CW  target channel
- in_data  in  DW  signed partial sum
- clr_valid  in  1  dump/clear request
- clr_ready  out  1  dump accept
- clr_chan  in  CW  channel to dump
- out_valid  out  1  result valid
- out_ready  in  1  result consumed
- out_chan  out  CW  channel of result
- out_data  out  AW  signed accumulated value before clear
- out_spike  out  1  out_data >= THRESH
- out_sat  out  1  channel saturated since its last dump
REQ-003 A handshake on any channel SHALL complete on a rising edge where valid and ready are both 1.

Function
REQ-004 Each channel SHALL hold a signed AW-bit accumulator acc[c] and a sticky saturation flag sat[c].
REQ-005 in_ready SHALL be 1 whenever rst_n is 1. The input path never stalls.
REQ-006 An input handshake SHALL set acc[in_chan] <= sat_add(acc[in_chan], sext(in_data)), visible on the next cycle.
REQ-007 sat_add SHALL clamp to [-2^(AW-1), 2^(AW-1)-1]. Any clamping SHALL set sat[chan].
REQ-008 clr_ready SHALL be 1 when !out_valid || out_ready. This gives a one-entry output register with same-cycle refill.
REQ-009 A dump handshake on channel c SHALL load the output register on the next edge with:
- out_chan = c
- out_data = acc[c]
- out_spike = (acc[c] >= THRESH)
- out_sat = sat[c]
- out_valid = 1
Latency is 1 cycle.
REQ-010 On the same edge as a dump, acc[c] SHALL become:
- THRESH subtracted, if RESET_MODE=1 and spiking
- 0, otherwise
sat[c] SHALL clear on that edge.
REQ-011 Output fields SHALL stay stable while out_valid=1 and out_ready=0.
REQ-012 If out_valid=1, out_ready=1 and no dump handshake occurs, out_valid SHALL go 0 on the next edge.
REQ-013 Same cycle, same channel, input and dump:
- out_data SHALL exclude the new input.
- acc[c] SHALL become residual + in_data, saturated.
- sat[c] SHALL reflect only that addition.
REQ-014 Same cycle, different channels, input and dump: both SHALL apply independently.
REQ-015 in_chan or clr_chan >= NCH SHALL be ignored: no state change. The handshake still completes.
REQ-016 Channels other than the addressed one SHALL never change.

Reset
REQ-017 While rst_n=0, the following SHALL be held asynchronously at 0:
- all acc[c] and sat[c]
- out_valid, out_data, out_chan, out_spike, out_sat
- in_ready and clr_ready
REQ-018 Reset mid-operation SHALL discard any pending output without a handshake.
REQ-019 The first handshake SHALL be accepted on the first rising edge after rst_n rises.

Verification (NCH=4, DW=8, AW=12, THRESH=100)
REQ-020 The bench SHALL cover the following scenarios:
- RESET_MODE=0: inputs ch1 +60 then +50, dump ch1. Expect out_data=110, out_spike=1, out_sat=0. Second dump ch1 gives 0.
- RESET_MODE=1: same stimulus. Expect first dump 110/spike=1, second dump 10/spike=0.
- Saturation: 20 x (+127) on ch0, dump. Expect out_data=2047, out_sat=1. Next dump gives 0/sat=0. Repeat with -128 to get -2048.
- Collision: ch2 acc=5. Same cycle: in ch2 +3 and dump ch2. Expect out_data=5, then a later dump gives 3. Also in ch3 +7 with dump ch2: ch3 gains 7.
- Backpressure: out_ready=0, dump ch0, then dump ch1 requested. Expect clr_ready=0 and output held. Set out_ready=1: ch1 result appears next cycle, no loss or duplication.
- Reset mid-op: out_valid=1, acc[1]=40, assert rst_n=0 asynchronously. Expect out_valid=0 immediately. After release, dump ch1 gives 0.
